decim_ctrl: RTL and testbench

- Sequences the DDC-to-decimator path per radar PRT: on a PRT trigger it discards a settling window, then emits every (R+1)-th DDC I/Q sample until N samples are taken.
- Drives a ready/valid stream to the downstream range-FFT buffer and reports overflow and trigger errors.
- Sits between the DDC output (continuous, one sample per clk_120m) and the range-processing FIFO.

---
 rtl/decim_ctrl_if.sv | 34 +++
 rtl/decim_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_decim_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/decim_ctrl_if.sv
// decim_ctrl_if -- decimated I/Q ready/valid stream toward the range-FFT buffer.
//
// Signals:
//   dout_I, dout_Q  decimated I/Q sample             (master -> slave)
//   dout_valid      sample valid                     (master -> slave)
//   dout_last       final sample of PRT, with valid  (master -> slave)
//   dout_ready      downstream accepts sample        (slave -> master)
//
// Modports: master (decim_ctrl side), slave (consumer side).
interface decim_ctrl_if #(
    parameter int unsigned DATA_W = 16
);
    logic [DATA_W-1:0] dout_I;
    logic [DATA_W-1:0] dout_Q;
    logic              dout_valid;
    logic              dout_last;
    logic              dout_ready;

    modport master (
        output dout_I,
        output dout_Q,
        output dout_valid,
        output dout_last,
        input  dout_ready
    );

    modport slave (
        input  dout_I,
        input  dout_Q,
        input  dout_valid,
        input  dout_last,
        output dout_ready
    );
endinterface

// File: rtl/decim_ctrl.sv
// decim_ctrl -- per-PRT DDC-to-decimator sequencer.
//
// On prt_trig, discards cfg_skip settling samples, then takes every
// (cfg_ratio+1)-th DDC I/Q sample until cfg_nsamp samples are taken,
// presenting them on a one-deep ready/valid output slot.
//
// Ports:
//   clk_120m       in   system clock, 120 MHz
//   rst_n          in   asynchronous active-low reset
//   cfg_ratio      in   decimation factor minus 1
//   cfg_skip       in   input samples discarded after trigger
//   cfg_nsamp      in   decimated samples per PRT
//   cfg_load       in   pulse: capture cfg_* into shadow registers
//   prt_trig       in   single-cycle PRT start pulse
//   din_I, din_Q   in   DDC I/Q, valid every cycle
//   dout           if   decim_ctrl_if.master (dout_I/Q, dout_valid,
//                       dout_last, dout_ready)
//   frame_done     out  one-cycle pulse at end of acquisition
//   busy           out  high in SKIP or ACQ
//   err_flags      out  sticky: [0] output overflow, [1] trigger while busy
//   err_clr        in   clears err_flags (a same-cycle set wins)
//
// Build option: define DECIM_ZERO_FILL_EN to force dout_I/dout_Q to zero
// whenever dout_valid is low; otherwise the last loaded sample is held.
module decim_ctrl #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned RATIO_W = 4,
    parameter int unsigned SKIP_W  = 8,
    parameter int unsigned NSAMP_W = 12
) (
    input  logic               clk_120m,
    input  logic               rst_n,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic [SKIP_W-1:0]  cfg_skip,
    input  logic [NSAMP_W-1:0] cfg_nsamp,
    input  logic               cfg_load,
    input  logic               prt_trig,
    input  logic [DATA_W-1:0]  din_I,
    input  logic [DATA_W-1:0]  din_Q,
    decim_ctrl_if.master       dout,
    output logic               frame_done,
    output logic               busy,
    output logic [1:0]         err_flags,
    input  logic               err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SKIP = 2'd1,
        ACQ  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Shadow (active) configuration and pending capture for loads while busy
    logic [RATIO_W-1:0] sh_ratio, pd_ratio;
    logic [SKIP_W-1:0]  sh_skip,  pd_skip;
    logic [NSAMP_W-1:0] sh_nsamp, pd_nsamp;
    logic               pd_flag;

    logic [SKIP_W-1:0]  skip_cnt;
    logic [RATIO_W-1:0] phase;
    logic [NSAMP_W-1:0] samp_cnt;

    logic [DATA_W-1:0]  slot_I, slot_Q;
    logic               slot_valid, slot_last;

    logic take, last_take, load_slot, drop, accept, trig_err;

    // Next state and per-cycle control
    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        last_take = 1'b0;
        case (state)
            IDLE: begin
                if (prt_trig && (sh_nsamp != '0)) begin
                    // A zero skip count bypasses SKIP entirely
                    state_nxt = (sh_skip == '0) ? ACQ : SKIP;
                end
            end
            SKIP: begin
                if (skip_cnt == sh_skip - SKIP_W'(1)) state_nxt = ACQ;
            end
            ACQ: begin
                take      = (phase == sh_ratio);
                last_take = take && (samp_cnt == sh_nsamp - NSAMP_W'(1));
                if (last_take) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = slot_valid && dout.dout_ready;
    assign load_slot = take && (!slot_valid || dout.dout_ready);
    assign drop      = take && !load_slot;
    assign trig_err  = prt_trig && (state != IDLE);

    // State and counters
    always_ff @(posedge clk_120m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            skip_cnt <= '0;
            phase    <= '0;
            samp_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= (state == SKIP) ? skip_cnt + SKIP_W'(1) : '0;
            if (state == ACQ) begin
                phase <= (phase == sh_ratio) ? '0 : phase + RATIO_W'(1);
                if (take) samp_cnt <= samp_cnt + NSAMP_W'(1);
            end else begin
                phase    <= '0;
                samp_cnt <= '0;
            end
        end
    end

    // Configuration shadowing: loads while busy are deferred to the
    // cycle the frame ends; a load on that very cycle takes precedence.
    always_ff @(posedge clk_120m or negedge rst_n) begin
        if (!rst_n) begin
            sh_ratio <= RATIO_W'(3);
            sh_skip  <= '0;
            sh_nsamp <= '0;
            pd_ratio <= '0;
            pd_skip  <= '0;
            pd_nsamp <= '0;
            pd_flag  <= 1'b0;
        end else if (state == IDLE) begin
            if (cfg_load) begin
                sh_ratio <= cfg_ratio;
                sh_skip  <= cfg_skip;
                sh_nsamp <= cfg_nsamp;
            end
        end else begin
            if (cfg_load) begin
                pd_ratio <= cfg_ratio;
                pd_skip  <= cfg_skip;
                pd_nsamp <= cfg_nsamp;
                pd_flag  <= 1'b1;
            end
            if (state_nxt == IDLE) begin
                pd_flag <= 1'b0;
                if (cfg_load) begin
                    sh_ratio <= cfg_ratio;
                    sh_skip  <= cfg_skip;
                    sh_nsamp <= cfg_nsamp;
                end else if (pd_flag) begin
                    sh_ratio <= pd_ratio;
                    sh_skip  <= pd_skip;
                    sh_nsamp <= pd_nsamp;
                end
            end
        end
    end

    // Output slot, frame_done and sticky errors
    always_ff @(posedge clk_120m or negedge rst_n) begin
        if (!rst_n) begin
            slot_I     <= '0;
            slot_Q     <= '0;
            slot_valid <= 1'b0;
            slot_last  <= 1'b0;
            frame_done <= 1'b0;
            err_flags  <= '0;
        end else begin
            if (load_slot) begin
                slot_I     <= din_I;
                slot_Q     <= din_Q;
                slot_valid <= 1'b1;
                slot_last  <= last_take;
            end else if (accept) begin
                slot_valid <= 1'b0;
                slot_last  <= 1'b0;
            end
            frame_done <= last_take;
            err_flags  <= (err_flags & ~{2{err_clr}}) | {trig_err, drop};
        end
    end

    assign busy            = (state != IDLE);
    assign dout.dout_valid = slot_valid;
    assign dout.dout_last  = slot_last;
`ifdef DECIM_ZERO_FILL_EN
    assign dout.dout_I = slot_valid ? slot_I : '0;
    assign dout.dout_Q = slot_valid ? slot_Q : '0;
`else
    assign dout.dout_I = slot_I;
    assign dout.dout_Q = slot_Q;
`endif

endmodule

// File: tb/tb_decim_ctrl.sv
// tb_decim_ctrl -- directed self-checking bench for decim_ctrl.
module tb_decim_ctrl;

    logic        clk_120m = 1'b0;
    logic        rst_n;
    logic [3:0]  cfg_ratio;
    logic [7:0]  cfg_skip;
    logic [11:0] cfg_nsamp;
    logic        cfg_load;
    logic        prt_trig;
    logic [15:0] din_I, din_Q;
    logic        frame_done, busy, err_clr;
    logic [1:0]  err_flags;

    decim_ctrl_if #(.DATA_W(16)) dif ();

    decim_ctrl #(
        .DATA_W(16), .RATIO_W(4), .SKIP_W(8), .NSAMP_W(12)
    ) dut (
        .clk_120m  (clk_120m),
        .rst_n     (rst_n),
        .cfg_ratio (cfg_ratio),
        .cfg_skip  (cfg_skip),
        .cfg_nsamp (cfg_nsamp),
        .cfg_load  (cfg_load),
        .prt_trig  (prt_trig),
        .din_I     (din_I),
        .din_Q     (din_Q),
        .dout      (dif),
        .frame_done(frame_done),
        .busy      (busy),
        .err_flags (err_flags),
        .err_clr   (err_clr)
    );

    always #5 clk_120m = ~clk_120m;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [15:0] ramp;
    int          iter;
    int          fd_cnt;
    int          fd_cyc;
    logic        busy_seen;
    logic [15:0] cap_I[$];
    logic [15:0] cap_Q[$];
    logic        cap_last[$];
    int          cap_cyc[$];
    logic        obs_valid[$];
    logic [15:0] obs_I[$];
    logic [15:0] exp_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_120m);
        @(negedge clk_120m);
    endtask

    task automatic new_frame(input logic [15:0] start);
        ramp      = start;
        iter      = 0;
        fd_cnt    = 0;
        fd_cyc    = -1;
        busy_seen = 1'b0;
        cap_I.delete();
        cap_Q.delete();
        cap_last.delete();
        cap_cyc.delete();
        obs_valid.delete();
        obs_I.delete();
    endtask

    task automatic load_cfg(input logic [3:0] r, input logic [7:0] s, input logic [11:0] n);
        cfg_ratio = r;
        cfg_skip  = s;
        cfg_nsamp = n;
        cfg_load  = 1'b1;
        tick();
        cfg_load  = 1'b0;
    endtask

    task automatic trig();
        din_I    = 16'hFFFF;
        din_Q    = 16'hFFFF;
        prt_trig = 1'b1;
        tick();
        prt_trig = 1'b0;
    endtask

    // Drive a ramp, one value per cycle, recording what the slot shows
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            din_I = ramp;
            din_Q = ramp + 16'd1000;
            ramp  = ramp + 16'd1;
            tick();
            obs_valid.push_back(dif.dout_valid);
            obs_I.push_back(dif.dout_I);
            if (dif.dout_valid && dif.dout_ready) begin
                cap_I.push_back(dif.dout_I);
                cap_Q.push_back(dif.dout_Q);
                cap_last.push_back(dif.dout_last);
                cap_cyc.push_back(iter);
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = iter;
            end
            if (busy) busy_seen = 1'b1;
            iter++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_ratio = '0; cfg_skip = '0; cfg_nsamp = '0; cfg_load = 1'b0;
        prt_trig = 1'b0; din_I = '0; din_Q = '0; err_clr = 1'b0;
        dif.dout_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", dif.dout_valid, 0);
        check("rst_I",     dif.dout_I, 0);
        check("rst_last",  dif.dout_last, 0);
        check("rst_fd",    frame_done, 0);
        check("rst_busy",  busy, 0);
        check("rst_err",   err_flags, 0);
        rst_n = 1'b1;
        tick();

        // ratio 3, skip 2, nsamp 4: ramp 0.. gives 5,9,13,17
        load_cfg(4'd3, 8'd2, 12'd4);
        trig();
        check("t1_busy_skip", busy, 1);
        new_frame(16'd0);
        run(22);
        check("t1_ncap", cap_I.size(), 4);
        check("t1_s0", cap_I[0], 5);
        check("t1_s1", cap_I[1], 9);
        check("t1_s2", cap_I[2], 13);
        check("t1_s3", cap_I[3], 17);
        check("t1_q3", cap_Q[3], 1017);
        check("t1_cyc0", cap_cyc[0], 5);
        check("t1_last2", cap_last[2], 0);
        check("t1_last3", cap_last[3], 1);
        check("t1_fdcnt", fd_cnt, 1);
        check("t1_fdcyc", fd_cyc, 17);
        check("t1_busy_end", busy, 0);
        check("t1_err", err_flags, 0);

        // ratio 0, skip 0, nsamp 3: back-to-back outputs
        load_cfg(4'd0, 8'd0, 12'd3);
        trig();
        new_frame(16'd100);
        run(6);
        check("t2_ncap", cap_I.size(), 3);
        check("t2_s0", cap_I[0], 100);
        check("t2_s1", cap_I[1], 101);
        check("t2_s2", cap_I[2], 102);
        check("t2_cyc0", cap_cyc[0], 0);
        check("t2_cyc2", cap_cyc[2], 2);
        check("t2_last", cap_last[2], 1);
        check("t2_fdcyc", fd_cyc, 2);

        // ratio 0, nsamp 4, downstream stalled: overflow
        load_cfg(4'd0, 8'd0, 12'd4);
        dif.dout_ready = 1'b0;
        trig();
        new_frame(16'd200);
        run(4);
        check("t3_valid", dif.dout_valid, 1);
        check("t3_held", dif.dout_I, 200);
        check("t3_last", dif.dout_last, 0);
        check("t3_err", err_flags, 2'b01);
        check("t3_fdcyc", fd_cyc, 3);
        dif.dout_ready = 1'b1;
        tick();
        check("t3_drain", dif.dout_valid, 0);
`ifdef DECIM_ZERO_FILL_EN
        exp_hold = 16'd0;
`else
        exp_hold = 16'd200;
`endif
        check("t3_idle_I", dif.dout_I, exp_hold);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("t3_clr", err_flags, 2'b00);

        // ratio 1, skip 1, nsamp 3 with retrigger and cfg_load mid-ACQ
        load_cfg(4'd1, 8'd1, 12'd3);
        trig();
        new_frame(16'd300);
        run(3);
        prt_trig  = 1'b1;
        cfg_ratio = 4'd0; cfg_skip = 8'd0; cfg_nsamp = 12'd2;
        cfg_load  = 1'b1;
        run(1);
        prt_trig  = 1'b0;
        cfg_load  = 1'b0;
        run(6);
        check("t4_ncap", cap_I.size(), 3);
        check("t4_s0", cap_I[0], 302);
        check("t4_s2", cap_I[2], 306);
        check("t4_fdcyc", fd_cyc, 6);
        check("t4_err", err_flags, 2'b10);
        trig();
        new_frame(16'd400);
        run(4);
        check("t4b_ncap", cap_I.size(), 2);
        check("t4b_s1", cap_I[1], 401);
        check("t4b_last", cap_last[1], 1);
        check("t4b_fdcyc", fd_cyc, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // nsamp 0: trigger ignored
        load_cfg(4'd2, 8'd3, 12'd0);
        trig();
        check("t5_busy_now", busy, 0);
        new_frame(16'd0);
        run(6);
        check("t5_busy_seen", busy_seen, 0);
        check("t5_ncap", cap_I.size(), 0);
        check("t5_fd", fd_cnt, 0);
        check("t5_err", err_flags, 0);

        // Asynchronous reset during ACQ with a sample pending
        load_cfg(4'd0, 8'd0, 12'd8);
        trig();
        new_frame(16'd500);
        run(3);
        check("t6_pre_valid", dif.dout_valid, 1);
        check("t6_pre_I", dif.dout_I, 502);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", dif.dout_valid, 0);
        check("t6_rst_I", dif.dout_I, 0);
        check("t6_rst_busy", busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        load_cfg(4'd1, 8'd0, 12'd2);
        trig();
        new_frame(16'd600);
        run(5);
        check("t6_ncap", cap_I.size(), 2);
        check("t6_s0", cap_I[0], 601);
        check("t6_s1", cap_I[1], 603);
        check("t6_cyc1", cap_cyc[1], 3);
        check("t6_gap_valid", obs_valid[2], 0);
`ifdef DECIM_ZERO_FILL_EN
        exp_hold = 16'd0;
`else
        exp_hold = 16'd601;
`endif
        check("t6_gap_I", obs_I[2], exp_hold);
        check("t6_fdcyc", fd_cyc, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
